// File: rtl/mem_resp_pkg.sv
// Shared state encoding and default geometry for the mem_responder memory target.
package mem_resp_pkg;

  typedef enum logic {CLEAR, IDLE} mresp_state_e;

  localparam int         DEF_DEPTH     = 32;
  localparam int         DEF_DW        = 8;
  localparam int         DEF_AW        = 5;
  localparam int         DEF_CW        = 16;
  localparam logic [7:0] DEF_CLEAR_VAL = 8'h00;

endpackage

// File: rtl/mem_resp_array.sv
// DEPTH x DW storage with one synchronous write port and one registered read port.
module mem_resp_array #(
  parameter int DEPTH = 32,
  parameter int DW    = 8,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  // NOTE: the array has no reset so it can map onto RAM; the post-reset clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: clears its array after reset, then services single-cycle
// read/write strobes, flags protocol errors and counts completed accesses.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int          DEPTH     = DEF_DEPTH,
  parameter int          DW        = DEF_DW,
  parameter int          AW        = DEF_AW,
  parameter logic [DW-1:0] CLEAR_VAL = DW'(DEF_CLEAR_VAL),
  parameter int          CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  input  logic          read,
  input  logic          write,
  output logic [DW-1:0] data_out,
  output logic          rd_valid,
  output logic          busy,
  output logic          err,
  output logic [CW-1:0] acc_cnt
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mresp_state_e  r_state;
  logic [AW-1:0] r_clr_addr;
  logic          r_rd_valid;
  logic          r_err;
  logic [CW-1:0] r_acc_cnt;

  logic          w_busy;
  logic          w_addr_ok;
  logic          w_strobe;
  logic          w_proto_err;
  logic          w_do_write;
  logic          w_do_read;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;

  assign w_busy = (r_state == CLEAR);

  // Only a non-power-of-two depth leaves addresses that fall outside the array.
  if ((1 << AW) > DEPTH) begin : g_range_chk
    assign w_addr_ok = (addr <= LAST_ADDR);
  end else begin : g_full_range
    assign w_addr_ok = 1'b1;
  end

  assign w_strobe    = read | write;
  assign w_proto_err = w_strobe & (w_busy | (read & write) | ~w_addr_ok);
  assign w_do_write  = ~w_busy & write & ~read & w_addr_ok;
  assign w_do_read   = ~w_busy & read & ~write & w_addr_ok;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
    end else if (r_state == CLEAR) begin
      r_clr_addr <= r_clr_addr + AW'(1);
      if (r_clr_addr == LAST_ADDR) r_state <= IDLE;
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_we    = w_do_write;
    w_waddr = addr;
    w_wdata = data_in;
    if (w_busy) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
      w_wdata = CLEAR_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_acc_cnt  <= '0;
    end else begin
      r_rd_valid <= w_do_read;
      if (w_proto_err) r_err <= 1'b1;
      if ((w_do_read || w_do_write) && (r_acc_cnt != '1)) r_acc_cnt <= r_acc_cnt + CW'(1);
    end
  end

  mem_resp_array #(
    .DEPTH (DEPTH),
    .DW    (DW),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_do_read),
    .i_raddr (addr),
    .o_rdata (data_out)
  );

  assign rd_valid = r_rd_valid;
  assign busy     = w_busy;
  assign err      = r_err;
  assign acc_cnt  = r_acc_cnt;

endmodule
